input_port_ctrl: RTL and testbench
==================================

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, flit buffer entries; power of two, at least 4.
REQ-003 SHALL take ADDR_WIDTH and NUM_PORTS from packet_pkg, both 4.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream flit valid.
REQ-007 in_ready  output  1  buffer can accept a flit.
REQ-008 in_data  input  DATA_WIDTH  flit; on header flit, bits [ADDR_WIDTH-1:0] are the one-hot/multicast destination mask.
REQ-009 in_sop  input  1  marks header flit.
REQ-010 in_eop  input  1  marks last flit; may coincide with in_sop for a single-flit packet.
REQ-011 port_req  output  1  request to arbiter.
REQ-012 port_dst  output  ADDR_WIDTH  destination mask presented to arbiter.
REQ-013 grant  input  1  this port's arbiter grant bit, combinational in the same cycle as port_req.
REQ-014 out_valid  output  1  flit on out_data is transferred this cycle.
REQ-015 out_data  output  DATA_WIDTH  flit to crossbar.
REQ-016 out_eop  output  1  last flit of the transferred packet.
REQ-017 drop_cnt  output  8  saturating count of dropped packets.

Function
REQ-018 SHALL buffer flits in a FIFO_DEPTH-entry FIFO storing {sop, eop, data}; a write occurs when in_valid and in_ready.
REQ-019 in_ready SHALL equal "FIFO not full"; a same-cycle pop SHALL NOT be used to accept a write when full.
REQ-020 SHALL run a FSM with states IDLE, REQ, XFER, DROP.
REQ-021 IDLE: when the FIFO is non-empty and the head flit has sop=1, latch head mask into port_dst; go to REQ if the mask is non-zero, else go to DROP.
REQ-022 IDLE: a head flit with sop=0 SHALL be popped and discarded without counting.
REQ-023 REQ: port_req=1 and port_dst held stable; stay in REQ until grant=1, then go to XFER next cycle; no timeout.
REQ-024 XFER: pop one flit per cycle while the FIFO is non-empty, driving out_valid=1, out_data and out_eop from the head.
REQ-025 XFER: if the FIFO is empty mid-packet, out_valid=0 for that cycle (bubble) and the state stays XFER.
REQ-026 The first XFER flit SHALL be the header, one cycle after the grant cycle, aligned to the arbiter's registered mux select.
REQ-027 XFER: on popping a flit with eop=1, go to IDLE; the next header may begin REQ no earlier than the following cycle.
REQ-028 DROP: pop one flit per cycle without asserting out_valid until an eop flit is popped, then increment drop_cnt (saturating at 255) and go to IDLE.
REQ-029 port_req SHALL be 0 in every state except REQ; a grant received outside REQ SHALL be ignored.
REQ-030 Pointer and count arithmetic SHALL wrap modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.
REQ-031 A simultaneous push and pop when neither full nor empty SHALL leave the count unchanged.

Reset
REQ-032 On rst_n low, the FSM SHALL enter IDLE and the FIFO SHALL be emptied.
REQ-033 On rst_n low: in_ready=0; port_req, out_valid and out_eop=0; port_dst, out_data and drop_cnt=0.
REQ-034 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-035 Reset mid-packet SHALL discard all buffered flits and return to IDLE with no partial transfer resumed.

Verification
REQ-036 Single-flit packet: sop=eop=1, mask 4'b0010, grant held high -> port_req high one cycle; one flit out with out_valid=1 and out_eop=1 on the cycle after grant.
REQ-037 4-flit packet, mask 4'b0101, grant withheld 5 cycles -> port_req and port_dst=4'b0101 stable for 5 cycles; 4 consecutive out_valid cycles starting one cycle after grant; eop on the 4th.
REQ-038 Fill: 8 flits with no grant -> in_ready=0 after the 8th write; the 9th flit is not accepted until the first pop.
REQ-039 Zero mask: 3-flit packet with mask 4'b0000 -> no port_req, no out_valid, drop_cnt=1; the next valid packet is served normally.
REQ-040 Upstream gap: header and 1 payload flit, 3-cycle gap, then eop flit, granted -> out_valid pattern 1,1,0,0,0,1; state stays XFER during the gap.
REQ-041 Reset mid-XFER after 2 of 4 flits -> all outputs zero immediately; in_ready=1 after the first post-reset edge; FIFO empty.

Source files
------------

// File: rtl/input_port_ctrl.sv
// Router input port: flit FIFO plus request/transfer/drop sequencer.
// Presents the head packet's destination mask to the arbiter.
package packet_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_PORTS  = 4;
endpackage

module input_port_ctrl
  import packet_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  port_req,
  output logic [ADDR_WIDTH-1:0] port_dst,
  input  logic                  grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eop,
  output logic [7:0]            drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } state_t;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  rdy_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head;
  logic                  head_sop;
  logic                  head_eop;
  logic [DATA_WIDTH-1:0] head_data;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] dst_d;
  logic [7:0]            drop_q;
  logic                  drop_inc;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);

  // in_ready is held low through reset and rises on the first edge after it.
  assign in_ready = rdy_q & ~full;
  assign push     = in_valid & in_ready;

  assign head      = mem_q[rd_ptr_q];
  assign head_sop  = head[EW-1];
  assign head_eop  = head[EW-2];
  assign head_data = head[DATA_WIDTH-1:0];

  // Ready-enable flag: cleared by reset, set on every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // Flit storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_sop, in_eop, in_data};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FSM state, latched destination mask and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dst_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      if (drop_inc && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Next-state, pop and handshake decode.
  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    pop       = 1'b0;
    port_req  = 1'b0;
    out_valid = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_sop) begin
            dst_d   = head_data[ADDR_WIDTH-1:0];
            state_d = (|head_data[ADDR_WIDTH-1:0]) ? REQ : DROP;
          end else begin
            pop = 1'b1;
          end
        end
      end
      REQ: begin
        port_req = 1'b1;
        if (grant) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (!empty) begin
          pop       = 1'b1;
          out_valid = 1'b1;
          if (head_eop) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_eop) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign port_dst = dst_q;
  assign out_data = out_valid ? head_data : '0;
  assign out_eop  = out_valid & head_eop;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_input_port_ctrl;
  import packet_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        port_req;
  logic [3:0]  port_dst;
  logic        grant = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_eop;
  logic [7:0]  drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  input_port_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .port_req(port_req), .port_dst(port_dst), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_eop(out_eop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s, input logic e);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    step();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_port_req", 32'(port_req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_eop", 32'(out_eop), 0);
    chk("rst_port_dst", 32'(port_dst), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(in_ready), 0);
    step();
    chk("rdy_after_edge", 32'(in_ready), 1);

    // Single-flit packet, grant held high
    grant = 1'b1;
    push(32'hA000_0002, 1'b1, 1'b1);
    chk("t1_req_idle", 32'(port_req), 0);
    step();
    chk("t1_req", 32'(port_req), 1);
    chk("t1_dst", 32'(port_dst), 32'h2);
    chk("t1_ov_req", 32'(out_valid), 0);
    step();
    chk("t1_ov", 32'(out_valid), 1);
    chk("t1_eop", 32'(out_eop), 1);
    chk("t1_data", out_data, 32'hA000_0002);
    chk("t1_req_xfer", 32'(port_req), 0);
    step();
    chk("t1_ov_done", 32'(out_valid), 0);
    chk("t1_req_done", 32'(port_req), 0);
    grant = 1'b0;

    // 4-flit packet, grant withheld 5 cycles
    push(32'hB000_0005, 1'b1, 1'b0);
    push(32'hB000_0011, 1'b0, 1'b0);
    push(32'hB000_0012, 1'b0, 1'b0);
    push(32'hB000_0013, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_hold", 32'(port_req), 1);
      chk("t2_dst_hold", 32'(port_dst), 32'h5);
      chk("t2_ov_hold", 32'(out_valid), 0);
      step();
    end
    grant = 1'b1;
    step();
    grant = 1'b0;
    chk("t2_hdr", out_data, 32'hB000_0005);
    for (int k = 0; k < 4; k++) begin
      chk("t2_ov", 32'(out_valid), 1);
      chk("t2_eop", 32'(out_eop), (k == 3) ? 1 : 0);
      if (k > 0) chk("t2_data", out_data, 32'hB000_0010 + 32'(k));
      step();
    end
    chk("t2_ov_done", 32'(out_valid), 0);
    chk("t2_req_done", 32'(port_req), 0);

    // Fill to full with no grant
    push(32'hC000_0001, 1'b1, 1'b0);
    for (int k = 1; k < 7; k++) push(32'hC000_0010 + 32'(k), 1'b0, 1'b0);
    push(32'hC000_0017, 1'b0, 1'b1);
    chk("t3_full", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 32'hD000_0008;
    in_sop   = 1'b1;
    in_eop   = 1'b1;
    step();
    chk("t3_full_wait1", 32'(in_ready), 0);
    step();
    chk("t3_full_wait2", 32'(in_ready), 0);
    grant = 1'b1;
    step();
    grant = 1'b0;
    chk("t3_full_popcyc", 32'(in_ready), 0);
    chk("t3_ov0", 32'(out_valid), 1);
    chk("t3_d0", out_data, 32'hC000_0001);
    step();
    chk("t3_rdy_after_pop", 32'(in_ready), 1);
    chk("t3_ov1", 32'(out_valid), 1);
    chk("t3_d1", out_data, 32'hC000_0011);
    step();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    for (int k = 2; k < 8; k++) begin
      chk("t3_ov", 32'(out_valid), 1);
      chk("t3_data", out_data, 32'hC000_0010 + 32'(k));
      chk("t3_eop", 32'(out_eop), (k == 7) ? 1 : 0);
      step();
    end
    chk("t3_ov_idle", 32'(out_valid), 0);
    step();
    chk("t3_9_req", 32'(port_req), 1);
    chk("t3_9_dst", 32'(port_dst), 32'h8);
    grant = 1'b1;
    step();
    grant = 1'b0;
    chk("t3_9_ov", 32'(out_valid), 1);
    chk("t3_9_eop", 32'(out_eop), 1);
    chk("t3_9_data", out_data, 32'hD000_0008);
    step();
    chk("t3_9_done", 32'(out_valid), 0);

    // Zero-mask packet is dropped, then a good packet is served
    push(32'hE000_0000, 1'b1, 1'b0);
    push(32'hE000_0011, 1'b0, 1'b0);
    push(32'hE000_0012, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_req", 32'(port_req), 0);
      chk("t4_no_ov", 32'(out_valid), 0);
      step();
    end
    chk("t4_drop_cnt", 32'(drop_cnt), 1);
    grant = 1'b1;
    push(32'hF000_0004, 1'b1, 1'b1);
    chk("t4_idle_req", 32'(port_req), 0);
    step();
    chk("t4_req", 32'(port_req), 1);
    chk("t4_dst", 32'(port_dst), 32'h4);
    step();
    chk("t4_ov", 32'(out_valid), 1);
    chk("t4_eop", 32'(out_eop), 1);
    chk("t4_data", out_data, 32'hF000_0004);
    step();
    chk("t4_done", 32'(out_valid), 0);

    // Upstream gap inside a granted packet
    push(32'h9000_0002, 1'b1, 1'b0);
    push(32'h9000_0011, 1'b0, 1'b0);
    step();
    grant = 1'b0;
    chk("t5_ov_1", 32'(out_valid), 1);
    chk("t5_d_1", out_data, 32'h9000_0002);
    step();
    chk("t5_ov_2", 32'(out_valid), 1);
    chk("t5_d_2", out_data, 32'h9000_0011);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_bubble_ov", 32'(out_valid), 0);
      chk("t5_bubble_req", 32'(port_req), 0);
    end
    push(32'h9000_0012, 1'b0, 1'b1);
    chk("t5_ov_6", 32'(out_valid), 1);
    chk("t5_eop_6", 32'(out_eop), 1);
    chk("t5_d_6", out_data, 32'h9000_0012);
    step();
    chk("t5_done", 32'(out_valid), 0);

    // Reset in the middle of a transfer
    grant = 1'b1;
    push(32'h7000_000F, 1'b1, 1'b0);
    push(32'h7000_0011, 1'b0, 1'b0);
    push(32'h7000_0012, 1'b0, 1'b0);
    push(32'h7000_0013, 1'b0, 1'b1);
    step();
    chk("t6_mid_ov", 32'(out_valid), 1);
    chk("t6_mid_data", out_data, 32'h7000_0012);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", 32'(in_ready), 0);
    chk("t6_rst_req", 32'(port_req), 0);
    chk("t6_rst_ov", 32'(out_valid), 0);
    chk("t6_rst_eop", 32'(out_eop), 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_dst", 32'(port_dst), 0);
    chk("t6_rst_drop", 32'(drop_cnt), 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_rdy_pre", 32'(in_ready), 0);
    step();
    chk("t6_rdy_post", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_resume_ov", 32'(out_valid), 0);
      chk("t6_no_resume_req", 32'(port_req), 0);
      step();
    end
    push(32'h6000_0001, 1'b1, 1'b1);
    step();
    step();
    chk("t6_new_ov", 32'(out_valid), 1);
    chk("t6_new_data", out_data, 32'h6000_0001);
    step();
    chk("t6_new_done", 32'(out_valid), 0);
    grant = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
